am_entropy_core: RTL and testbench

AM_ENTROPY_CORE -- requirements
Module: am_entropy_core

---
 rtl/am_pkg.sv | 19 +
 rtl/am_vn_debias.sv | 31 +++
 rtl/am_entropy_core.sv | 149 ++++++++++++++
 tb/tb_am_entropy_core.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/am_pkg.sv
// Shared types and constants for the entropy core: FSM state encoding,
// LFSR feedback taps (x^16+x^14+x^13+x^11+1) and the default LFSR seed.
package am_pkg;

  typedef enum logic [1:0] {
    AM_IDLE  = 2'd0,
    AM_FILL  = 2'd1,
    AM_FAULT = 2'd2
  } am_state_e;

  // Bits 15,13,12,10 of the state feed the XOR that enters at bit 0.
  localparam logic [15:0] AM_LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] AM_DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] am_lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & AM_LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/am_vn_debias.sv
// Von Neumann debiaser: pairs raw samples, emits the first sample of a
// 10/01 pair on the second sample's cycle, discards 00/11 pairs.
module am_vn_debias (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic raw_valid,
  input  logic raw_bit,
  output logic bit_valid,
  output logic bit_o
);

  logic phase_q;  // 0: expecting first sample, 1: expecting second
  logic first_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= 1'b0;
      first_q <= 1'b0;
    end else if (clear) begin
      phase_q <= 1'b0;
    end else if (raw_valid) begin
      phase_q <= ~phase_q;
      if (!phase_q) first_q <= raw_bit;
    end
  end

  assign bit_valid = raw_valid && phase_q && (first_q != raw_bit);
  assign bit_o     = first_q;

endmodule

// File: rtl/am_entropy_core.sv
// Entropy core: debiases raw noise into DATA_W-bit words whitened by a free
// running LFSR. Define AM_ENTROPY_HEALTH_EN to add the repetition-count test.
module am_entropy_core
  import am_pkg::*;
#(
  parameter int          DATA_W     = 8,
  parameter int          RCT_CUTOFF = 32,
  parameter logic [15:0] LFSR_SEED  = AM_DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              raw_valid,
  input  logic              raw_bit,
  input  logic              ent_ready,
  output logic [DATA_W-1:0] ent_o,
  output logic              ent_valid,
  output logic              fault,
  input  logic              fault_clr,
  output am_state_e         state_o
);

  if (DATA_W < 1 || DATA_W > 16 || RCT_CUTOFF < 2 || RCT_CUTOFF > 255) begin : g_bad_param
    $error("am_entropy_core: parameter out of range");
  end

  localparam logic [15:0] SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam int          CW       = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_W);

  // Output handshake: ent_o is offered while ent_valid=1 and is consumed on
  // any edge where ent_ready=1; a word may load on the same edge it is consumed.
  am_state_e         state_q, state_d;
  logic [15:0]       lfsr_q;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] ent_o_q, ent_o_d;
  logic              ent_valid_q, ent_valid_d;
  logic              sample_ok, clear, trip, take, load;
  logic              bit_valid, bit_o;

  assign sample_ok = (state_q == AM_FILL) && en && raw_valid;
  assign clear     = (state_d != AM_FILL);

  am_vn_debias u_debias (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .raw_valid (sample_ok),
    .raw_bit   (raw_bit),
    .bit_valid (bit_valid),
    .bit_o     (bit_o)
  );

`ifdef AM_ENTROPY_HEALTH_EN
  logic       last_q, last_d;
  logic [7:0] rct_q, rct_d, rct_inc;

  assign rct_inc = (rct_q != 8'd0 && raw_bit == last_q) ? rct_q + 8'd1 : 8'd1;
  assign trip    = sample_ok && (rct_inc == 8'(RCT_CUTOFF));

  always_comb begin
    rct_d  = rct_q;
    last_d = last_q;
    if (clear) begin
      rct_d = 8'd0;
    end else if (sample_ok) begin
      rct_d  = rct_inc;
      last_d = raw_bit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rct_q  <= 8'd0;
      last_q <= 1'b0;
    end else begin
      rct_q  <= rct_d;
      last_q <= last_d;
    end
  end

  assign fault = (state_q == AM_FAULT);
`else
  assign trip  = 1'b0;
  assign fault = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    if (trip) begin
      state_d = AM_FAULT;
    end else begin
      case (state_q)
        AM_IDLE:  if (en)        state_d = AM_FILL;
        AM_FILL:  if (!en)       state_d = AM_IDLE;
        AM_FAULT: if (fault_clr) state_d = AM_IDLE;
        default:                 state_d = AM_IDLE;
      endcase
    end
  end

  // A full accumulator stalls (dropping new bits) until the output slot frees.
  assign take = bit_valid && !clear && (cnt_q != CNT_FULL);
  assign load = (cnt_q == CNT_FULL) && (!ent_valid_q || ent_ready) && (state_d != AM_FAULT);

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ent_o_d     = ent_o_q;
    ent_valid_d = ent_valid_q;
    if (take) begin
      acc_d = DATA_W'({acc_q, bit_o});
      cnt_d = cnt_q + 1'b1;
    end
    if (clear || load) cnt_d = '0;
    if (state_d == AM_FAULT) begin
      ent_valid_d = 1'b0;
    end else if (load) begin
      ent_o_d     = acc_q ^ lfsr_q[DATA_W-1:0];
      ent_valid_d = 1'b1;
    end else if (ent_ready) begin
      ent_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= AM_IDLE;
      lfsr_q      <= SEED;
      acc_q       <= '0;
      cnt_q       <= '0;
      ent_o_q     <= '0;
      ent_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= am_lfsr_next(lfsr_q);
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ent_o_q     <= ent_o_d;
      ent_valid_q <= ent_valid_d;
    end
  end

  assign ent_o     = ent_o_q;
  assign ent_valid = ent_valid_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_am_entropy_core.sv
// Directed bench for am_entropy_core (DATA_W=8); the health scenario is built
// when AM_ENTROPY_HEALTH_EN is defined, otherwise fault must stay low.
module tb_am_entropy_core;
  import am_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en, raw_valid, raw_bit, ent_ready, fault_clr;
  logic [7:0] ent_o;
  logic       ent_valid, fault;
  am_state_e  state_o;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_exp;
  logic [7:0] held;
  logic [15:0] m_lfsr, m_prev;

  am_entropy_core #(.DATA_W(8), .RCT_CUTOFF(32), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .en(en), .raw_valid(raw_valid), .raw_bit(raw_bit),
    .ent_ready(ent_ready), .ent_o(ent_o), .ent_valid(ent_valid), .fault(fault),
    .fault_clr(fault_clr), .state_o(state_o)
  );

  // ---------------- clock / reset / reference LFSR ----------------
  always #5 clk = ~clk;

  // m_prev holds the LFSR value present just before the most recent edge,
  // i.e. the whitening value used by a word that loaded on that edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr = 16'hACE1;
      m_prev = 16'hACE1;
    end else begin
      m_prev = m_lfsr;
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_word(input string tag);
    logic [7:0] w;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      w = exp_q.pop_front();
      last_exp = w ^ m_prev[7:0];
      check({tag, "_valid"}, {31'd0, ent_valid}, 32'd1);
      check({tag, "_data"}, {24'd0, ent_o}, {24'd0, last_exp});
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_sample(input logic s);
    raw_valid = 1'b1;
    raw_bit   = s;
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    send_sample(b);
    send_sample(~b);
  endtask

  task automatic send_word(input logic [7:0] w);
    exp_q.push_back(w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic idle();
    raw_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic consume();
    ent_ready = 1'b1;
    @(negedge clk);
    ent_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; en = 1'b0; raw_valid = 1'b0; raw_bit = 1'b0;
    ent_ready = 1'b0; fault_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", state_o, AM_IDLE);
    check("rst_valid", ent_valid, 0);
    check("rst_data", ent_o, 0);
    check("rst_fault", fault, 0);
    rst = 1'b0;
    @(negedge clk);

    // all-ones word from eight 10 pairs
    en = 1'b1;
    @(negedge clk);
    check("fill_state", state_o, AM_FILL);
    send_word(8'hFF);
    idle();
    check_word("ones");
    consume();
    check("consume_valid", ent_valid, 0);

    // 00 and 11 pairs discarded, only 01 contributes zeros
    for (int r = 0; r < 8; r++) begin
      send_sample(1'b0); send_sample(1'b0);
      send_sample(1'b1); send_sample(1'b1);
      send_sample(1'b0); send_sample(1'b1);
    end
    exp_q.push_back(8'h00);
    idle();
    check_word("discard");
    consume();

    send_word(8'hA5);
    idle();
    check_word("mixed");
    consume();

    // back-pressure: first word held, second stalls, extra bits dropped
    send_word(8'h3C);
    idle();
    check_word("bp_first");
    held = last_exp;
    send_word(8'hC3);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    idle();
    check("bp_hold_data", ent_o, held);
    check("bp_hold_valid", ent_valid, 1);
    ent_ready = 1'b1;
    @(negedge clk);
    ent_ready = 1'b0;
    check_word("bp_second");
    @(negedge clk);
    check("bp_second_stays", ent_valid, 1);
    consume();
    check("bp_drained", ent_valid, 0);

    // fault_clr outside FAULT has no effect
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check("clr_ignored", state_o, AM_FILL);

    // reset mid-word discards partial accumulation
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    raw_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_state", state_o, AM_IDLE);
    check("midrst_data", ent_o, 0);
    check("midrst_valid", ent_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_refill", state_o, AM_FILL);
    exp_q.push_back(8'h5A);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    idle();
    check("midrst_7bits", ent_valid, 0);
    send_bit(1'b0);
    idle();
    check_word("midrst_word");
    held = last_exp;

    // en dropped mid-word: count restarts, retained output unchanged
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    raw_valid = 1'b0;
    en = 1'b0;
    @(negedge clk);
    check("endrop_state", state_o, AM_IDLE);
    check("endrop_valid", ent_valid, 1);
    check("endrop_data", ent_o, held);
    consume();
    check("endrop_consume", ent_valid, 0);
    en = 1'b1;
    @(negedge clk);
    exp_q.push_back(8'h96);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    idle();
    check("endrop_5bits", ent_valid, 0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    idle();
    check_word("endrop_word");
    consume();

`ifdef AM_ENTROPY_HEALTH_EN
    send_word(8'h0F);
    idle();
    check_word("pre_fault");
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 31; i++) send_sample(1'b1);
    check("rct_31_fault", fault, 0);
    check("rct_31_valid", ent_valid, 1);
    send_sample(1'b1);
    raw_valid = 1'b0;
    check("rct_32_fault", fault, 1);
    check("rct_32_valid", ent_valid, 0);
    check("rct_32_state", state_o, AM_FAULT);
    @(negedge clk);
    check("fault_sticky", state_o, AM_FAULT);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check("clr_state", state_o, AM_IDLE);
    check("clr_fault", fault, 0);
    @(negedge clk);
    check("resume_state", state_o, AM_FILL);
    send_word(8'h69);
    idle();
    check_word("resume_word");
    consume();
`else
    for (int i = 0; i < 40; i++) send_sample(1'b1);
    idle();
    check("no_health_fault", fault, 0);
    check("no_health_state", state_o, AM_FILL);
    check("no_health_valid", ent_valid, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
